score_display: RTL
==================

Name: score_display

Overview:
- Downstream consumer of the game-state and apple-eaten signals produced by the game controller and apple generator in the top level.
- Keeps a 4-digit BCD score of apples eaten in the current game and a best-score register that survives game restarts.
- Drives four active-low 7-segment digits (HEX3..HEX0): live score in PLAY, blinking final score in DIE, best score in START.
- Runs on the 25 MHz game clock alongside the other game blocks.

Parameters:
- BLINK_HALF, 6250000, number of clk cycles per blink half-period in DIE; 2 Hz at 25 MHz; minimum 2.
- ST_START, 3'b001, game_status encoding for the start screen.
- ST_PLAY, 3'b010, game_status encoding for active play.
- ST_DIE, 3'b100, game_status encoding for game over.

Ports:
- clk  input  1  game clock (25 MHz domain).
- rst_n  input  1  reset; asynchronous assert, active-low.
- game_status  input  3  one-hot game state from game_ctrl; synchronous to clk.
- body_add_sig  input  1  high (one or more cycles) when the snake eats an apple; synchronous to clk.
- score_bcd  output  16  current score, 4 BCD digits, [15:12] = thousands.
- best_bcd  output  16  best score since reset, 4 BCD digits.
- hex0  output  7  units digit segments {g,f,e,d,c,b,a}, active-low.
- hex1  output  7  tens digit segments.
- hex2  output  7  hundreds digit segments.
- hex3  output  7  thousands digit segments.

Behaviour:
- Reset (rst_n low, asynchronous): score_bcd=0, best_bcd=0, blink counter=0, blink phase=on, add_d=0, prev_status=ST_START, hex0..hex3=7'h7F (blank). All registers clear immediately, including mid-game.
- Edge detect: add_d registers body_add_sig each cycle; eat_pulse = body_add_sig & ~add_d. A multi-cycle-high body_add_sig counts once.
- Score increment: on a clk edge where eat_pulse=1 and game_status==ST_PLAY, score_bcd increments by one in BCD, visible after that edge.
  - Digit 9 rolls to 0 and carries into the next digit.
  - Saturates at 9999: a further eat leaves the value unchanged.
  - eat_pulse in any state other than ST_PLAY is ignored.
- New game: on the edge where game_status changes into ST_START from any other value, score_bcd clears to 0. Detection uses prev_status, registered every cycle.
  - A single-cycle ST_START between DIE and PLAY still clears the score.
  - If an eat_pulse coincides with that edge, the clear wins.
- Best score: on every edge where game_status==ST_DIE and score_bcd > best_bcd (BCD compare from the most-significant digit down), best_bcd <= score_bcd. best_bcd is never cleared except by reset.
- Blink: a counter runs only while game_status==ST_DIE.
  - It counts 0..BLINK_HALF-1, wraps, and toggles the blink phase on the wrap.
  - On leaving ST_DIE, counter=0 and phase=on.
- Display source (registered, 1-cycle latency from the selected value to hex*):
  - ST_PLAY: score_bcd.
  - ST_DIE: score_bcd when phase=on, all digits 7'h7F when phase=off.
  - ST_START: best_bcd.
  - Any other game_status encoding (0 or multi-hot): all digits show dash 7'b0111111; score and best hold.
- Segment table (active-low, {g..a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - BCD values 10..15 are unreachable; they decode to 7'h7F.
- Total latency: eat sampled at edge N -> score_bcd updated at N -> hex updated at N+1.

Optional Feature:
- Macro: SCORE_LEAD_ZERO_BLANK_EN.
- Defined: leading zero digits are blanked (7'h7F) on hex3..hex1 wherever a number is shown; hex0 always shows its digit, so 0 displays as a single "0" and 42 displays as blank,blank,"4","2". Dash and blink-off displays are unchanged.
- Undefined: all four digits always show, e.g. "0042".
- score_bcd and best_bcd are identical in both builds.

Test Plan:
- Reset with rst_n low mid-count -> score_bcd=0, best_bcd=0, hex0..hex3=7'h7F immediately, without waiting for a clk edge.
- PLAY; pulse body_add_sig 3 times (one held high for 5 cycles) -> score_bcd=16'h0003; one cycle later hex0=7'h30, hex1..hex3=7'h40 (lead-zero macro undefined).
- PLAY with score preloaded by 9999 eats; one more eat -> stays 16'h9999. Separately, 0009 -> 0010 and 0099 -> 0100 carry correctly.
- PLAY score 0012 -> DIE with BLINK_HALF=4 -> best_bcd=16'h0012; hex alternates "0012" / 7'h7F every 4 cycles. An eat during DIE leaves the score at 0012.
- DIE -> START (1 cycle) -> PLAY -> score_bcd=0 and best_bcd=0012. In START, hex shows "0012". Eat coinciding with the START entry edge -> score stays 0.
- game_status=3'b011 -> all hex=7'b0111111 and score/best unchanged. With SCORE_LEAD_ZERO_BLANK_EN defined and score 0007 in PLAY -> hex3..hex1=7'h7F, hex0=7'h78.

Source files
------------

// File: rtl/score_display.sv
// Score keeper and 4-digit 7-segment driver for the snake game.
// Optional macro SCORE_LEAD_ZERO_BLANK_EN blanks leading zero digits on hex3..hex1.
module score_display #(
  parameter int unsigned BLINK_HALF = 6250000,
  parameter logic [2:0]  ST_START   = 3'b001,
  parameter logic [2:0]  ST_PLAY    = 3'b010,
  parameter logic [2:0]  ST_DIE     = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  game_status,
  input  logic        body_add_sig,
  output logic [15:0] score_bcd,
  output logic [15:0] best_bcd,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam int unsigned CW       = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    DISP_NUM,
    DISP_BLANK,
    DISP_DASH
  } disp_mode_e;

  logic                add_q;
  logic [2:0]          prev_status_q;
  logic [15:0]         score_q, score_d;
  logic [15:0]         best_q, best_d;
  logic [CW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_on_q, blink_on_d;
  logic [3:0][6:0]     hex_q, hex_d;

  logic                eat_pulse;
  logic                new_game;
  disp_mode_e          disp_mode;
  logic [15:0]         disp_val;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign eat_pulse = body_add_sig & ~add_q;
  assign new_game  = (game_status == ST_START) && (prev_status_q != ST_START);

  // Clear on START entry takes priority over a coincident eat.
  always_comb begin
    score_d = score_q;
    if (new_game) begin
      score_d = '0;
    end else if (eat_pulse && (game_status == ST_PLAY) && (score_q != SCORE_MAX)) begin
      score_d = bcd_inc(score_q);
    end
  end

  // Digits are ordered most-significant first, so a plain unsigned compare is a BCD compare.
  always_comb begin
    best_d = best_q;
    if ((game_status == ST_DIE) && (score_q > best_q)) begin
      best_d = score_q;
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (game_status == ST_DIE) begin
      blink_on_d = blink_on_q;
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    disp_mode = DISP_DASH;
    disp_val  = '0;
    case (game_status)
      ST_PLAY: begin
        disp_mode = DISP_NUM;
        disp_val  = score_q;
      end
      ST_DIE: begin
        disp_mode = blink_on_q ? DISP_NUM : DISP_BLANK;
        disp_val  = score_q;
      end
      ST_START: begin
        disp_mode = DISP_NUM;
        disp_val  = best_q;
      end
      default: begin
        disp_mode = DISP_DASH;
        disp_val  = '0;
      end
    endcase
  end

  always_comb begin
    hex_d = '1;
    case (disp_mode)
      DISP_NUM: begin
        for (int unsigned i = 0; i < 4; i++) begin
          hex_d[i] = seg7(disp_val[i*4 +: 4]);
        end
`ifdef SCORE_LEAD_ZERO_BLANK_EN
        if (disp_val[15:12] == 4'd0) hex_d[3] = SEG_BLANK;
        if (disp_val[15:8]  == 8'd0) hex_d[2] = SEG_BLANK;
        if (disp_val[15:4]  == 12'd0) hex_d[1] = SEG_BLANK;
`endif
      end
      DISP_BLANK: begin
        for (int unsigned i = 0; i < 4; i++) begin
          hex_d[i] = SEG_BLANK;
        end
      end
      default: begin
        for (int unsigned i = 0; i < 4; i++) begin
          hex_d[i] = SEG_DASH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q         <= 1'b0;
      prev_status_q <= ST_START;
      score_q       <= '0;
      best_q        <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      hex_q         <= '1;
    end else begin
      add_q         <= body_add_sig;
      prev_status_q <= game_status;
      score_q       <= score_d;
      best_q        <= best_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      hex_q         <= hex_d;
    end
  end

  assign score_bcd = score_q;
  assign best_bcd  = best_q;
  assign hex0      = hex_q[0];
  assign hex1      = hex_q[1];
  assign hex2      = hex_q[2];
  assign hex3      = hex_q[3];

endmodule
